// File: rtl/lpif_pkg.sv
// Shared LPIF TX definitions: generator FSM states and Gen2 PHY word bit locations.
package lpif_pkg;

  typedef enum logic [1:0] {OFFLINE, PREP, RUN} tx_gen_state_e;

  localparam int unsigned LPIF_STB_GEN2_LOC = 1;
  localparam int unsigned LPIF_MRK_GEN2_LOC = 77;

endpackage

// File: rtl/lpif_wrap_cnt.sv
// Up-counter that returns to zero after reaching a runtime limit.
module lpif_wrap_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         wrap_c
);

  // >= keeps the counter bounded even if it ever sits above the limit
  assign wrap_c = (cnt >= limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap_c ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/lpif_tx_stb_mrk_gen.sv
// TX strobe/marker userbit generator feeding the LPIF TX concatenation stage.
module lpif_tx_stb_mrk_gen
  import lpif_pkg::*;
#(
  parameter int unsigned STB_INTV_W   = 8,
  parameter int unsigned PREP_CYC     = 4,
  parameter int unsigned MRK_GRP_GEN2 = 2,
  parameter int unsigned MRK_GRP_GEN1 = 1
) (
  input  logic                  clk_wr,
  input  logic                  rst_wr_n,
  input  logic                  tx_online,
  input  logic                  m_gen2_mode,
  input  logic                  cfg_stb_en,
  input  logic                  cfg_mrk_en,
  input  logic [STB_INTV_W-1:0] cfg_stb_intv,
  output logic                  tx_stb_userbit,
  output logic [0:0]            tx_mrk_userbit,
  output logic                  tx_gen_active,
  output logic [STB_INTV_W-1:0] tx_stb_cnt
);

  localparam int unsigned PREP_W  = 4;
  localparam int unsigned GRP_MAX = (MRK_GRP_GEN2 > MRK_GRP_GEN1) ? MRK_GRP_GEN2 : MRK_GRP_GEN1;
  localparam int unsigned GRP_W   = (GRP_MAX > 1) ? $clog2(GRP_MAX) : 1;

  tx_gen_state_e state, next_state;

  logic [PREP_W-1:0]     prep_cnt;
  logic                  sh_stb_en;
  logic                  sh_mrk_en;
  logic                  sh_gen2;
  logic [STB_INTV_W-1:0] sh_intv;

  logic                  run_c;
  logic [STB_INTV_W-1:0] stb_lim_c;
  logic [GRP_W-1:0]      grp_lim_c;
  logic [STB_INTV_W-1:0] stb_cnt;
  logic [GRP_W-1:0]      grp_cnt;
  logic                  stb_wrap_unused;
  logic                  grp_wrap_c;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state <= OFFLINE;
    end else begin
      state <= next_state;
    end
  end

  // Dropping tx_online overrides every other transition
  always_comb begin
    next_state = state;
    if (!tx_online) begin
      next_state = OFFLINE;
    end else begin
      unique case (state)
        OFFLINE: next_state = PREP;
        PREP:    next_state = (prep_cnt == '0) ? RUN : PREP;
        RUN:     next_state = RUN;
        default: next_state = OFFLINE;
      endcase
    end
  end

  // Config is captured only when leaving OFFLINE, so mid-link changes wait for the next bring-up
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      sh_stb_en <= 1'b0;
      sh_mrk_en <= 1'b0;
      sh_gen2   <= 1'b0;
      sh_intv   <= '0;
    end else if (state == OFFLINE && tx_online) begin
      sh_stb_en <= cfg_stb_en;
      sh_mrk_en <= cfg_mrk_en;
      sh_gen2   <= m_gen2_mode;
      sh_intv   <= cfg_stb_intv;
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      prep_cnt <= '0;
    end else if (state == OFFLINE) begin
      prep_cnt <= tx_online ? PREP_W'(PREP_CYC - 1) : '0;
    end else if (state == PREP && prep_cnt != '0) begin
      prep_cnt <= prep_cnt - PREP_W'(1);
    end
  end

  assign run_c     = (state == RUN) && tx_online;
  assign stb_lim_c = (sh_intv == '0) ? '0 : sh_intv - STB_INTV_W'(1);
  assign grp_lim_c = sh_gen2 ? GRP_W'(MRK_GRP_GEN2 - 1) : GRP_W'(MRK_GRP_GEN1 - 1);

  // Both counters are held clear outside RUN so they start in phase on RUN entry
  lpif_wrap_cnt #(.W(STB_INTV_W)) u_stb_cnt (
    .clk    (clk_wr),
    .rst_n  (rst_wr_n),
    .clr    (!run_c),
    .en     (run_c),
    .limit  (stb_lim_c),
    .cnt    (stb_cnt),
    .wrap_c (stb_wrap_unused)
  );

  lpif_wrap_cnt #(.W(GRP_W)) u_grp_cnt (
    .clk    (clk_wr),
    .rst_n  (rst_wr_n),
    .clr    (!run_c),
    .en     (run_c),
    .limit  (grp_lim_c),
    .cnt    (grp_cnt),
    .wrap_c (grp_wrap_c)
  );

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      tx_stb_userbit <= 1'b0;
      tx_mrk_userbit <= 1'b0;
      tx_gen_active  <= 1'b0;
      tx_stb_cnt     <= '0;
    end else begin
      tx_stb_userbit <= run_c && sh_stb_en && (stb_cnt == '0);
      tx_mrk_userbit <= 1'(run_c && sh_mrk_en && grp_wrap_c);
      tx_gen_active  <= run_c;
      tx_stb_cnt     <= run_c ? stb_cnt : '0;
    end
  end

endmodule

// File: tb/tb_lpif_tx_stb_mrk_gen.sv
// Directed self-checking bench for the TX strobe/marker generator.
module tb_lpif_tx_stb_mrk_gen;

  localparam int unsigned W = 8;

  logic         clk_wr;
  logic         rst_wr_n;
  logic         tx_online;
  logic         m_gen2_mode;
  logic         cfg_stb_en;
  logic         cfg_mrk_en;
  logic [W-1:0] cfg_stb_intv;
  logic         tx_stb_userbit;
  logic [0:0]   tx_mrk_userbit;
  logic         tx_gen_active;
  logic [W-1:0] tx_stb_cnt;

  int n_tests;
  int n_fail;

  lpif_tx_stb_mrk_gen #(
    .STB_INTV_W   (W),
    .PREP_CYC     (4),
    .MRK_GRP_GEN2 (2),
    .MRK_GRP_GEN1 (1)
  ) dut (
    .clk_wr         (clk_wr),
    .rst_wr_n       (rst_wr_n),
    .tx_online      (tx_online),
    .m_gen2_mode    (m_gen2_mode),
    .cfg_stb_en     (cfg_stb_en),
    .cfg_mrk_en     (cfg_mrk_en),
    .cfg_stb_intv   (cfg_stb_intv),
    .tx_stb_userbit (tx_stb_userbit),
    .tx_mrk_userbit (tx_mrk_userbit),
    .tx_gen_active  (tx_gen_active),
    .tx_stb_cnt     (tx_stb_cnt)
  );

  initial clk_wr = 1'b0;
  always #5 clk_wr = ~clk_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_outs(input string tag, input logic s, input logic m,
                             input logic a, input logic [W-1:0] c);
    chk({tag, ".stb"}, 32'(tx_stb_userbit), 32'(s));
    chk({tag, ".mrk"}, 32'(tx_mrk_userbit), 32'(m));
    chk({tag, ".act"}, 32'(tx_gen_active), 32'(a));
    chk({tag, ".cnt"}, 32'(tx_stb_cnt), 32'(c));
  endtask

  task automatic step();
    @(posedge clk_wr);
    #1;
  endtask

  // n clock edges with every output expected low
  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      expect_outs($sformatf("%s[%0d]", tag, i), 1'b0, 1'b0, 1'b0, '0);
    end
  endtask

  // RUN words k0..k0+n-1: strobe on phase 0 of period iv, marker on last word of group g
  task automatic run_check(input string tag, input int n, input int iv, input int g,
                           input logic s_en, input logic m_en, input int k0);
    for (int k = k0; k < k0 + n; k++) begin
      step();
      expect_outs($sformatf("%s[%0d]", tag, k),
                  s_en && ((k % iv) == 0),
                  m_en && ((k % g) == (g - 1)),
                  1'b1,
                  W'(k % iv));
    end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_wr_n     = 1'b0;
    tx_online    = 1'b0;
    m_gen2_mode  = 1'b1;
    cfg_stb_en   = 1'b1;
    cfg_mrk_en   = 1'b1;
    cfg_stb_intv = 8'd4;

    #12;
    expect_outs("rst", 1'b0, 1'b0, 1'b0, '0);
    rst_wr_n = 1'b1;
    quiet("idle", 20);

    // Gen2, I=4: four quiet edges of PREP plus the latch edge, then 1000 / 0101
    tx_online = 1'b1;
    quiet("prep", 5);
    run_check("g2i4", 12, 4, 2, 1'b1, 1'b1, 0);

    cfg_stb_intv = 8'd6;
    run_check("cfgchg", 8, 4, 2, 1'b1, 1'b1, 12);

    tx_online = 1'b0;
    step();
    expect_outs("drop1", 1'b0, 1'b0, 1'b0, '0);
    tx_online = 1'b1;
    quiet("prep2", 5);
    run_check("i6", 12, 6, 2, 1'b1, 1'b1, 0);

    run_check("i6b", 3, 6, 2, 1'b1, 1'b1, 12);
    tx_online = 1'b0;
    step();
    expect_outs("offph2", 1'b0, 1'b0, 1'b0, '0);

    // I=max(0,1)=1 and Gen1 group of 1: both bits every word
    cfg_stb_intv = 8'd0;
    m_gen2_mode  = 1'b0;
    tx_online    = 1'b1;
    quiet("prep3", 5);
    run_check("i1g1", 8, 1, 1, 1'b1, 1'b1, 0);

    // PREP glitch restarts the quiet window
    tx_online = 1'b0;
    step();
    expect_outs("drop2", 1'b0, 1'b0, 1'b0, '0);
    cfg_stb_intv = 8'd3;
    m_gen2_mode  = 1'b1;
    cfg_mrk_en   = 1'b0;
    tx_online    = 1'b1;
    quiet("glA", 2);
    tx_online = 1'b0;
    quiet("glB", 1);
    tx_online = 1'b1;
    quiet("glC", 5);
    run_check("i3", 7, 3, 2, 1'b1, 1'b0, 0);

    // Asynchronous reset between edges, tx_online kept high
    cfg_stb_intv = 8'd2;
    cfg_mrk_en   = 1'b1;
    #3;
    rst_wr_n = 1'b0;
    #1;
    expect_outs("arst", 1'b0, 1'b0, 1'b0, '0);
    #2;
    rst_wr_n = 1'b1;
    quiet("arstprep", 5);
    run_check("i2", 6, 2, 2, 1'b1, 1'b1, 0);

    tx_online = 1'b0;
    step();
    expect_outs("drop3", 1'b0, 1'b0, 1'b0, '0);
    cfg_stb_en   = 1'b0;
    m_gen2_mode  = 1'b0;
    cfg_stb_intv = 8'd5;
    tx_online    = 1'b1;
    quiet("prep4", 5);
    run_check("stboff", 5, 5, 1, 1'b0, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
